// File: rtl/multimode_modulator.sv
// ============================================================================
// multimode_modulator : symbol-timed BPSK / ASK / QPSK / pilot modulator.
// Optional build macro: MODULATOR_QPSK_EN (adds the quadrature datapath).
// Revision: 1.0
// ============================================================================
`default_nettype none

module multimode_modulator #(
  parameter int OUTPUT_WIDTH  = 12,
  parameter int SYM_LEN_WIDTH = 16,
  parameter int ASK_LOW_SHIFT = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [1:0]                     mode_sel,
  input  logic [SYM_LEN_WIDTH-1:0]       sym_len,
  input  logic [1:0]                     data_in,
  input  logic                           data_valid,
  output logic                           data_ready,
  input  logic [OUTPUT_WIDTH-1:0]        sine_c,
  input  logic [OUTPUT_WIDTH-1:0]        cosine_c,
  output logic signed [OUTPUT_WIDTH:0]   mod_out,
  output logic                           busy,
  output logic                           sym_strobe,
  output logic                           underrun
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SYM_LEN_WIDTH-1:0] CNT_ONE = SYM_LEN_WIDTH'(1);

  state_t                          state_q, state_d;
  logic [SYM_LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic [1:0]                      sym_q, sym_d;
  logic [1:0]                      mode_q, mode_d;
  logic signed [OUTPUT_WIDTH:0]    mod_q, mod_d;
  logic                            strobe_q, strobe_d;
  logic                            underrun_q, underrun_d;
  logic                            xfer;

  logic signed [OUTPUT_WIDTH:0]    s_ext;
  logic signed [OUTPUT_WIDTH:0]    ask_low;
  logic signed [OUTPUT_WIDTH:0]    mapped;

  // Gated by rst so the handshake reads 0 while reset is held.
  assign data_ready = en && !rst && ((state_q == IDLE) || (cnt_q == '0));
  assign xfer       = data_valid && data_ready;

  assign s_ext = $signed({sine_c[OUTPUT_WIDTH-1], sine_c});

  generate
    if (ASK_LOW_SHIFT == 0) begin : g_ask_ook
      assign ask_low = '0;
    end else begin : g_ask_shift
      assign ask_low = s_ext >>> ASK_LOW_SHIFT;
    end
  endgenerate

`ifdef MODULATOR_QPSK_EN
  logic signed [OUTPUT_WIDTH+1:0]  c_w, s_w, sum_w;
  logic signed [OUTPUT_WIDTH:0]    qpsk_val;

  assign c_w   = $signed({{2{cosine_c[OUTPUT_WIDTH-1]}}, cosine_c});
  assign s_w   = $signed({{2{sine_c[OUTPUT_WIDTH-1]}}, sine_c});
  assign sum_w = (sym_q[1] ? c_w : -c_w) + (sym_q[0] ? s_w : -s_w);
  // Halving keeps the full +/-2^OW sum range inside OW+1 bits.
  assign qpsk_val = (OUTPUT_WIDTH+1)'(sum_w >>> 1);
`else
  logic unused_qpsk;
  assign unused_qpsk = ^{cosine_c, sym_q[1]};
`endif

  always_comb begin
    mapped = s_ext;
    case (mode_q)
      2'b00:   mapped = sym_q[0] ? s_ext : -s_ext;
      2'b01:   mapped = sym_q[0] ? s_ext : ask_low;
`ifdef MODULATOR_QPSK_EN
      2'b10:   mapped = qpsk_val;
`else
      2'b10:   mapped = sym_q[0] ? s_ext : -s_ext;
`endif
      default: mapped = s_ext;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sym_d      = sym_q;
    mode_d     = mode_q;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;
    mod_d      = (state_q == RUN) ? mapped : '0;
    if (xfer) begin
      sym_d    = data_in;
      mode_d   = mode_sel;
      cnt_d    = sym_len;
      state_d  = RUN;
      strobe_d = 1'b1;
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        // Boundary with no new symbol: underrun only counts while enabled.
        state_d    = IDLE;
        underrun_d = en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sym_q      <= '0;
      mode_q     <= '0;
      mod_q      <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sym_q      <= sym_d;
      mode_q     <= mode_d;
      mod_q      <= mod_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign mod_out    = mod_q;
  assign busy       = (state_q == RUN);
  assign sym_strobe = strobe_q;
  assign underrun   = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_multimode_modulator.sv
// ============================================================================
// tb_multimode_modulator : directed vector bench for multimode_modulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multimode_modulator;

  logic               clk;
  logic               rst;
  logic               en;
  logic [1:0]         mode_sel;
  logic [15:0]        sym_len;
  logic [1:0]         data_in;
  logic               data_valid;
  logic [11:0]        sine_c;
  logic [11:0]        cosine_c;
  logic               data_ready, data_ready_b;
  logic signed [12:0] mod_out, mod_out_b;
  logic               busy, busy_b;
  logic               sym_strobe, sym_strobe_b;
  logic               underrun, underrun_b;

  int n_vec = 0;
  int n_err = 0;

`ifdef MODULATOR_QPSK_EN
  localparam int Q11 = 800;
  localparam int Q10 = 200;
  localparam int Q00 = -800;
`else
  localparam int Q11 = 600;
  localparam int Q10 = -600;
  localparam int Q00 = -600;
`endif

  multimode_modulator #(.OUTPUT_WIDTH(12), .SYM_LEN_WIDTH(16), .ASK_LOW_SHIFT(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel), .sym_len(sym_len),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .sine_c(sine_c), .cosine_c(cosine_c), .mod_out(mod_out), .busy(busy),
    .sym_strobe(sym_strobe), .underrun(underrun)
  );

  multimode_modulator #(.OUTPUT_WIDTH(12), .SYM_LEN_WIDTH(16), .ASK_LOW_SHIFT(0)) u_dut_ook (
    .clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel), .sym_len(sym_len),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready_b),
    .sine_c(sine_c), .cosine_c(cosine_c), .mod_out(mod_out_b), .busy(busy_b),
    .sym_strobe(sym_strobe_b), .underrun(underrun_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int en, mode, len, data, valid, sine, cosine;
    int rdy, mod, modb, busy, stb, und;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int en, input int mode, input int len, input int data,
                              input int valid, input int sine, input int cosine, input int rdy,
                              input int mod, input int modb, input int busy, input int stb,
                              input int und);
    vec_t v;
    v.en = en; v.mode = mode; v.len = len; v.data = data; v.valid = valid;
    v.sine = sine; v.cosine = cosine; v.rdy = rdy; v.mod = mod; v.modb = modb;
    v.busy = busy; v.stb = stb; v.und = und;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic check_all_zero(input string nm, input int idx);
    check({nm, "_mod"}, idx, int'(mod_out), 0);
    check({nm, "_busy"}, idx, int'(busy), 0);
    check({nm, "_strobe"}, idx, int'(sym_strobe), 0);
    check({nm, "_underrun"}, idx, int'(underrun), 0);
    check({nm, "_ready"}, idx, int'(data_ready), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode_sel = '0; sym_len = '0; data_in = '0;
    data_valid = 1'b0; sine_c = '0; cosine_c = '0;

    // en low in IDLE with valid offered: nothing accepted
    vecs.push_back(mk(0,0,3,1,1, 1000,0, 0,     0,     0, 0,0,0));
    // BPSK, sym_len=3, symbols 1 then 0 back to back, then boundary underrun
    vecs.push_back(mk(1,0,3,1,1, 1000,0, 1,     0,     0, 1,1,0));
    vecs.push_back(mk(1,0,3,0,0, 1000,0, 0,  1000,  1000, 1,0,0));
    vecs.push_back(mk(1,0,3,0,0, 1000,0, 0,  1000,  1000, 1,0,0));
    vecs.push_back(mk(1,0,3,0,0, 1000,0, 0,  1000,  1000, 1,0,0));
    vecs.push_back(mk(1,0,3,0,1, 1000,0, 1,  1000,  1000, 1,1,0));
    vecs.push_back(mk(1,0,3,0,0, 1000,0, 0, -1000, -1000, 1,0,0));
    vecs.push_back(mk(1,0,3,0,0, 1000,0, 0, -1000, -1000, 1,0,0));
    vecs.push_back(mk(1,0,3,0,0, 1000,0, 0, -1000, -1000, 1,0,0));
    vecs.push_back(mk(1,0,3,0,0, 1000,0, 1, -1000, -1000, 0,0,1));
    vecs.push_back(mk(1,0,3,0,0, 1000,0, 1,     0,     0, 0,0,0));
    // ASK, sym_len=0, sine=-2048: bit0 then bit1 (shift 2 vs on-off keying)
    vecs.push_back(mk(1,1,0,0,1, -2048,0, 1,     0,     0, 1,1,0));
    vecs.push_back(mk(1,1,0,1,1, -2048,0, 1,  -512,     0, 1,1,0));
    vecs.push_back(mk(1,1,0,1,0, -2048,0, 1, -2048, -2048, 0,0,1));
    vecs.push_back(mk(1,1,0,1,0, -2048,0, 1,     0,     0, 0,0,0));
    // QPSK mode, cos=+1000 sin=+600: data 11, 10, 00 one per clock
    vecs.push_back(mk(1,2,0,3,1, 600,1000, 1,   0,   0, 1,1,0));
    vecs.push_back(mk(1,2,0,2,1, 600,1000, 1, Q11, Q11, 1,1,0));
    vecs.push_back(mk(1,2,0,0,1, 600,1000, 1, Q10, Q10, 1,1,0));
    vecs.push_back(mk(1,2,0,0,0, 600,1000, 1, Q00, Q00, 0,0,1));
    vecs.push_back(mk(1,2,0,0,0, 600,1000, 1,   0,   0, 0,0,0));
    // BPSK bit 0 for 5 clocks; mode/len switched mid-symbol must not apply
    vecs.push_back(mk(1,0,4,0,1, 1000,0, 1,     0,     0, 1,1,0));
    vecs.push_back(mk(1,3,1,0,0, 1000,0, 0, -1000, -1000, 1,0,0));
    vecs.push_back(mk(1,3,1,0,0, 1000,0, 0, -1000, -1000, 1,0,0));
    vecs.push_back(mk(1,3,1,0,0, 1000,0, 0, -1000, -1000, 1,0,0));
    vecs.push_back(mk(1,3,1,0,0, 1000,0, 0, -1000, -1000, 1,0,0));
    vecs.push_back(mk(1,3,0,0,1, 1000,0, 1, -1000, -1000, 1,1,0));
    vecs.push_back(mk(1,3,0,0,0, 1000,0, 1,  1000,  1000, 0,0,1));
    vecs.push_back(mk(1,3,0,0,0, 1000,0, 1,     0,     0, 0,0,0));
    // Underrun, sym_len=2: pulse 3 cycles after acceptance
    vecs.push_back(mk(1,0,2,1,1, 1000,0, 1,    0,    0, 1,1,0));
    vecs.push_back(mk(1,0,2,1,0, 1000,0, 0, 1000, 1000, 1,0,0));
    vecs.push_back(mk(1,0,2,1,0, 1000,0, 0, 1000, 1000, 1,0,0));
    vecs.push_back(mk(1,0,2,1,0, 1000,0, 1, 1000, 1000, 0,0,1));
    vecs.push_back(mk(1,0,2,1,0, 1000,0, 1,    0,    0, 0,0,0));
    // en dropped mid-symbol: symbol completes, IDLE without underrun
    vecs.push_back(mk(1,0,2,1,1, 1000,0, 1,    0,    0, 1,1,0));
    vecs.push_back(mk(0,0,2,1,0, 1000,0, 0, 1000, 1000, 1,0,0));
    vecs.push_back(mk(0,0,2,1,0, 1000,0, 0, 1000, 1000, 1,0,0));
    vecs.push_back(mk(0,0,2,1,0, 1000,0, 0, 1000, 1000, 0,0,0));
    vecs.push_back(mk(0,0,2,1,0, 1000,0, 0,    0,    0, 0,0,0));

    // Reset state while rst is held
    #2;
    check_all_zero("reset", 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      en         = 1'(vecs[i].en);
      mode_sel   = 2'(vecs[i].mode);
      sym_len    = 16'(vecs[i].len);
      data_in    = 2'(vecs[i].data);
      data_valid = 1'(vecs[i].valid);
      sine_c     = 12'(vecs[i].sine);
      cosine_c   = 12'(vecs[i].cosine);
      #1;
      check("data_ready", i, int'(data_ready), vecs[i].rdy);
      @(posedge clk); #1;
      check("mod_out", i, int'(mod_out), vecs[i].mod);
      check("mod_out_ook", i, int'(mod_out_b), vecs[i].modb);
      check("busy", i, int'(busy), vecs[i].busy);
      check("sym_strobe", i, int'(sym_strobe), vecs[i].stb);
      check("underrun", i, int'(underrun), vecs[i].und);
    end

    // Asynchronous reset in the middle of a BPSK symbol
    en = 1'b1; mode_sel = 2'b00; sym_len = 16'd3; data_in = 2'b01;
    data_valid = 1'b1; sine_c = 12'd1000; cosine_c = '0;
    @(posedge clk); #1;
    data_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_mod", 0, int'(mod_out), 1000);
    check("pre_rst_busy", 0, int'(busy), 1);
    #3 rst = 1'b1;
    #1;
    check_all_zero("async_rst", 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", 2, int'(data_ready), 1);
    check("post_rst_busy", 2, int'(busy), 0);
    data_in = 2'b00; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    check("post_rst_accept_busy", 3, int'(busy), 1);
    check("post_rst_accept_strobe", 3, int'(sym_strobe), 1);
    @(posedge clk); #1;
    check("post_rst_mod", 4, int'(mod_out), -1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multimode_modulator.md
# multimode_modulator

Symbol-timed, multi-mode digital modulator with selectable BPSK, ASK, QPSK and pilot-carrier modes. It consumes symbols from the spreading/framing stage over a valid/ready handshake and holds each symbol for a programmable number of clocks. It mixes the symbols onto externally generated NCO sine/cosine samples and drives a registered signed sample toward the DAC interface. It supersedes the fixed BPSK/ASK selector by adding symbol timing, per-symbol mode latching, underrun detection and a quadrature mode.

## Interface
- OUTPUT_WIDTH, 12, width of the signed carrier samples; mod_out is OUTPUT_WIDTH+1 bits.
- SYM_LEN_WIDTH, 16, width of the symbol-length field.
- ASK_LOW_SHIFT, 2, arithmetic right shift applied to the carrier for ASK bit 0. Legal range is 0..OUTPUT_WIDTH-1; 0 selects on-off keying, where bit 0 outputs 0.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  modulator enable.
- mode_sel  in  2  mode: 00 BPSK, 01 ASK, 10 QPSK, 11 pilot (unmodulated).
- sym_len  in  SYM_LEN_WIDTH  symbol period minus one, in clocks.
- data_in  in  2  symbol; [1]=I, [0]=Q. BPSK/ASK use [0] only.
- data_valid  in  1  symbol available.
- data_ready  out  1  block accepts a symbol this cycle.
- sine_c  in  OUTPUT_WIDTH  signed NCO sine sample.
- cosine_c  in  OUTPUT_WIDTH  signed NCO cosine sample.
- mod_out  out  OUTPUT_WIDTH+1  signed modulated sample, registered.
- busy  out  1  high while in RUN.
- sym_strobe  out  1  one-cycle pulse after each symbol acceptance.
- underrun  out  1  one-cycle pulse when a symbol boundary passes with no data while enabled.

## Operation
- States:
  - IDLE: nothing in flight; mod_out = 0.
  - RUN: a symbol is being transmitted.
- data_ready is asserted when en=1 and either the state is IDLE, or the state is RUN with cnt==0. Transfer occurs when data_valid && data_ready.
- On transfer:
  - data_in, mode_sel and sym_len are latched into sym_reg, mode_reg and len_reg.
  - cnt is loaded with sym_len and the state becomes RUN.
  - sym_strobe pulses on the next cycle.
- RUN with cnt≠0: cnt decrements each clock. Input changes on mode_sel and sym_len have no effect mid-symbol.
- RUN with cnt==0, no transfer:
  - With en=1, the state goes to IDLE and underrun pulses.
  - With en=0, the state goes to IDLE with no underrun pulse.
- en low in IDLE: data_ready is 0 and the block stays in IDLE. en low in RUN: the current symbol completes; it is never truncated.
- Output mapping; s and c are sine_c and cosine_c sign-extended to OUTPUT_WIDTH+1:
  - BPSK: bit 1 → +s, bit 0 → −s. −(−2^(OW−1)) fits in OW+1 bits.
  - ASK: bit 1 → s; bit 0 → s>>>ASK_LOW_SHIFT, or 0 when ASK_LOW_SHIFT=0.
  - QPSK: compute (±c ± s) in OW+2 bits, where I=1 selects +c and Q=1 selects +s. The result is arithmetic-shifted right by 1, truncating toward −∞, then narrowed to OW+1.
  - Pilot: +s; symbols are still consumed and data is ignored.
- Reset values: state IDLE, cnt 0, all latched registers 0, and every output 0 (data_ready, mod_out, busy, sym_strobe, underrun).

## Timing
- Symbol period is sym_len+1 clocks. Back-to-back symbols produce no gap; with sym_len=0, data_ready stays high and one symbol is taken per clock.
- Latency:
  - Acceptance at edge T updates sym_reg and busy at T.
  - mod_out reflects the new symbol from edge T+1, using sine_c and cosine_c sampled at T+1.
  - sym_strobe is high during the cycle following edge T.
- In every cycle mod_out is the registered mapping of the current sym_reg/mode_reg and the carrier inputs: one-cycle carrier-to-output latency.
- Underrun at edge T: the state is IDLE at T, underrun is high in the following cycle, and mod_out = 0 from edge T+1.
- Simultaneous boundary and new data: the new symbol is accepted, with no underrun and no gap.
- rst asserted mid-symbol clears everything immediately, independent of clk. After release, the first symbol is accepted from IDLE.

## Configuration
- MODULATOR_QPSK_EN defined: mode 10 is QPSK as above.
- MODULATOR_QPSK_EN undefined: the QPSK datapath is removed, cosine_c is ignored, and mode 10 behaves exactly as BPSK on data_in[0].

## Test plan
- Reset mid-RUN (sym_len=3, BPSK): all outputs go 0 asynchronously; after release, data_ready=1 when en=1.
- BPSK with sym_len=3, symbols 1,0 back to back, sine_c=+1000: mod_out is +1000 for 4 cycles, then −1000 for 4 cycles. sym_strobe pulses every 4 cycles; no underrun.
- ASK with ASK_LOW_SHIFT=2, sine_c=−2048, bit 0: mod_out=−512. With ASK_LOW_SHIFT=0: mod_out=0.
- QPSK (macro on), cosine_c=+1000, sine_c=+600:
  - data 11 → +800.
  - data 10 → +200.
  - data 00 → −800.
  - Macro off: data 10 → −600 (BPSK on bit 0).
- Underrun: sym_len=2, one symbol with valid then deasserted. underrun pulses once 3 cycles after acceptance, busy falls, and mod_out is 0 on the next cycle. en dropped mid-symbol instead: same return to IDLE with no underrun pulse.
- Mode change mid-symbol (BPSK→pilot at cycle 1 of a 5-cycle symbol): the output stays BPSK until the next acceptance.
